// File: rtl/rom_stream_reader.sv
// rom_stream_reader: walks a 1-cycle-latency image ROM and streams its words.
// Define ROM_STREAM_LOOP_EN for continuous back-to-back frames.
module rom_stream_reader #(
  parameter  int DATA_WIDTH = 9,
  parameter  int DEPTH      = 19090,
  localparam int DEPTH_BITS = $clog2(DEPTH)
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_start,
  input  logic                  i_abort,
  output logic                  o_busy,
  output logic                  o_done,
  output logic [DEPTH_BITS-1:0] o_rom_addr,
  input  logic [DATA_WIDTH-1:0] i_rom_data,
  output logic [DATA_WIDTH-1:0] o_data,
  output logic                  o_valid,
  input  logic                  i_ready,
  output logic                  o_first,
  output logic                  o_last
);

  localparam logic [DEPTH_BITS-1:0] LAST_ADDR =
    DEPTH_BITS'(DEPTH - 1);
  localparam int EW = DATA_WIDTH + 2;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_DRAIN
  } state_t;

  state_t          r_state;
  logic            r_pending;
  logic            r_tag_first;
  logic            r_tag_last;
  logic [1:0]      r_count;
  logic            r_wr_ptr;
  logic            r_rd_ptr;
  logic [EW-1:0]   r_mem [2];

  logic [EW-1:0]   w_head;
  logic            w_pop;
  logic            w_issue;
  logic            w_last_hs;
  logic [2:0]      w_level;

  assign o_valid   = (r_count != 2'd0);
  assign w_head    = r_mem[r_rd_ptr];
  assign o_data    = o_valid ? w_head[EW-1:2] : '0;
  assign o_first   = o_valid & w_head[1];
  assign o_last    = o_valid & w_head[0];
  assign w_pop     = o_valid & i_ready;
  assign w_last_hs = w_pop & o_last;

  // Words in flight after this edge: never let it exceed the 2 FIFO slots.
  assign w_level = 3'(r_count) + 3'(r_pending) - 3'(w_pop);
  assign w_issue = (r_state == S_ISSUE) && (w_level < 3'd2);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state     <= S_IDLE;
      r_pending   <= 1'b0;
      r_tag_first <= 1'b0;
      r_tag_last  <= 1'b0;
      o_rom_addr  <= '0;
      o_busy      <= 1'b0;
      o_done      <= 1'b0;
    end else if (i_abort) begin
      r_state     <= S_IDLE;
      r_pending   <= 1'b0;
      r_tag_first <= 1'b0;
      r_tag_last  <= 1'b0;
      o_rom_addr  <= '0;
      o_busy      <= 1'b0;
      o_done      <= 1'b0;
    end else begin
      r_pending <= w_issue;
      o_done    <= w_last_hs;
      if (w_issue) begin
        r_tag_first <= (o_rom_addr == '0);
        r_tag_last  <= (o_rom_addr == LAST_ADDR);
        o_rom_addr  <= (o_rom_addr == LAST_ADDR) ?
                       '0 : o_rom_addr + 1'b1;
      end
      unique case (r_state)
        S_IDLE: begin
          if (i_start) begin
            r_state    <= S_ISSUE;
            o_busy     <= 1'b1;
            o_rom_addr <= '0;
          end
        end
        S_ISSUE: begin
`ifndef ROM_STREAM_LOOP_EN
          if (w_issue && (o_rom_addr == LAST_ADDR))
            r_state <= S_DRAIN;
`endif
        end
        S_DRAIN: begin
          if (w_last_hs) begin
            r_state <= S_IDLE;
            o_busy  <= 1'b0;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_count  <= 2'd0;
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
      for (int i = 0; i < 2; i++)
        r_mem[i] <= '0;
    end else if (i_abort) begin
      r_count  <= 2'd0;
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
    end else begin
      if (r_pending) begin
        r_mem[r_wr_ptr] <= {i_rom_data, r_tag_first, r_tag_last};
        r_wr_ptr        <= ~r_wr_ptr;
      end
      if (w_pop)
        r_rd_ptr <= ~r_rd_ptr;
      r_count <= r_count + 2'(r_pending) - 2'(w_pop);
    end
  end

endmodule
